// File: rtl/imm_ext_pipe.sv
// Two-stage immediate generator: S1 captures the instruction word and format select,
// S2 holds the sign/zero-extended immediate with a valid/ready handshake on both sides.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      Instr,
  input  logic [2:0]       ImmSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic             ImmErr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_ZIMM  = 3'b110,
    FMT_ILL   = 3'b111
  } fmt_e;

  // RV64 shifts carry a 6-bit shamt (instruction bit 25 included), RV32 only 5 bits.
  localparam int SH_W = (XLEN == 64) ? 6 : 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_v_q, s1_v_d;
  logic [31:7]      s1_instr_q, s1_instr_d;
  logic [2:0]       s1_src_q, s1_src_d;
  logic             s2_v_q, s2_v_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv, s1_adv, accept;
  logic [XLEN-1:0]  imm_calc;
  logic             err_calc;
  logic             sgn;

  assign s2_adv   = !s2_v_q | out_ready;
  assign s1_adv   = s1_v_q & s2_adv;
  assign in_ready = !flush & (!s1_v_q | s2_adv);
  assign accept   = in_valid & in_ready;
  assign sgn      = s1_instr_q[31];

  always_comb begin
    imm_calc = '0;
    err_calc = 1'b0;
    case (s1_src_q)
      FMT_I:     imm_calc = {{(XLEN-12){sgn}}, s1_instr_q[31:20]};
      FMT_S:     imm_calc = {{(XLEN-12){sgn}}, s1_instr_q[31:25], s1_instr_q[11:7]};
      FMT_B:     imm_calc = {{(XLEN-12){sgn}}, s1_instr_q[7], s1_instr_q[30:25],
                             s1_instr_q[11:8], 1'b0};
      FMT_J:     imm_calc = {{(XLEN-20){sgn}}, s1_instr_q[19:12], s1_instr_q[20],
                             s1_instr_q[30:21], 1'b0};
      FMT_U:     imm_calc = {{(XLEN-31){sgn}}, s1_instr_q[30:12], 12'b0};
      FMT_SHAMT: imm_calc = {{(XLEN-SH_W){1'b0}}, s1_instr_q[20 +: SH_W]};
      FMT_ZIMM:  imm_calc = {{(XLEN-5){1'b0}}, s1_instr_q[19:15]};
      default: begin
        imm_calc = '0;
        err_calc = 1'b1;
      end
    endcase
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_instr_d = s1_instr_q;
    s1_src_d   = s1_src_q;
    s2_v_d     = s2_v_q;
    imm_d      = imm_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    if (accept) begin
      s1_v_d     = 1'b1;
      s1_instr_d = Instr;
      s1_src_d   = ImmSrc;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    // S2 data only moves when S1 hands over, so a stalled result stays put.
    if (s2_adv) s2_v_d = s1_v_q;
    if (s1_adv) begin
      imm_d = imm_calc;
      err_d = err_calc;
    end

    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end

    // A result taken in the flush cycle still counts as delivered.
    if (s2_v_q && out_ready && err_q && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_instr_q <= '0;
      s1_src_q   <= '0;
      s2_v_q     <= 1'b0;
      imm_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_instr_q <= s1_instr_d;
      s1_src_q   <= s1_src_d;
      s2_v_q     <= s2_v_d;
      imm_q      <= imm_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign ImmExt    = imm_q;
  assign ImmErr    = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench: an RV32 instance (2-bit error counter) and an RV64 instance driven in lockstep.
module tb_imm_ext_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:7] instr;
  logic [2:0]  src;

  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic        err32, err64;
  logic [1:0]  cnt32;
  logic [7:0]  cnt64;

  int n_cmp = 0;
  int n_bad = 0;

  imm_ext_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .Instr(instr), .ImmSrc(src), .out_valid(out_valid32), .out_ready(out_ready),
    .ImmExt(imm32), .ImmErr(err32), .err_count(cnt32)
  );

  imm_ext_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .Instr(instr), .ImmSrc(src), .out_valid(out_valid64), .out_ready(out_ready),
    .ImmExt(imm64), .ImmErr(err64), .err_count(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] word, input logic [2:0] s);
    in_valid = v;
    instr    = word[31:7];
    src      = s;
  endtask

  initial begin
    vt[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[1] = '{32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[2] = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[3] = '{32'h0080006F, 3'b011, 32'h00000008, 64'h0000000000000008, 1'b0};
    vt[4] = '{32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0};
    vt[5] = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vt[6] = '{32'h03F01013, 3'b101, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vt[7] = '{32'hFFFFFFFF, 3'b110, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[8] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    #1;
    chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_err", {63'b0, err64}, 64'd0);
    chk("rst_cnt", {56'b0, cnt64}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready32}, 64'd1);

    // back-to-back stream over every format, one result per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 9) drive(1'b1, vt[k].word, vt[k].src);
      else       drive(1'b0, 32'h0, 3'b000);
      chk("stream_in_ready", {63'b0, in_ready64}, 64'd1);
      if (k >= 2) begin
        chk("stream_valid", {62'b0, out_valid32, out_valid64}, 64'd3);
        chk("stream_imm32", {32'b0, imm32}, {32'b0, vt[k-2].e32});
        chk("stream_imm64", imm64, vt[k-2].e64);
        chk("stream_err", {62'b0, err32, err64}, {62'b0, vt[k-2].err, vt[k-2].err});
      end else begin
        chk("stream_lat", {63'b0, out_valid32}, 64'd0);
      end
      tick();
    end
    chk("stream_drain", {63'b0, out_valid64}, 64'd0);
    chk("cnt32_first", {62'b0, cnt32}, 64'd1);
    chk("cnt64_first", {56'b0, cnt64}, 64'd1);

    // five more illegal results: 2-bit counter saturates at 3
    for (int k = 0; k < 7; k++) begin
      if (k < 5) drive(1'b1, 32'h0, 3'b111);
      else       drive(1'b0, 32'h0, 3'b000);
      tick();
    end
    chk("cnt32_sat", {62'b0, cnt32}, 64'd3);
    chk("cnt64_six", {56'b0, cnt64}, 64'd6);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'b000);
    chk("bp_ready_a", {63'b0, in_ready32}, 64'd1);
    tick();
    drive(1'b1, 32'h7FF00093, 3'b000);
    chk("bp_ready_b", {63'b0, in_ready32}, 64'd1);
    tick();
    drive(1'b1, 32'h80000093, 3'b000);
    chk("bp_ready_full", {63'b0, in_ready32}, 64'd0);
    chk("bp_valid", {63'b0, out_valid32}, 64'd1);
    chk("bp_imm_a", {32'b0, imm32}, 64'h1);
    tick();
    chk("bp_ready_hold", {63'b0, in_ready64}, 64'd0);
    chk("bp_imm_hold", imm64, 64'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_pop", {63'b0, in_ready32}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 3'b000);
    chk("bp_imm_b", {32'b0, imm32}, 64'h7FF);
    tick();
    chk("bp_imm_c", {32'b0, imm32}, 64'hFFFFF800);
    chk("bp_imm_c64", imm64, 64'hFFFFFFFFFFFFF800);
    tick();
    chk("bp_empty", {63'b0, out_valid32}, 64'd0);

    // flush with both stages full; the held illegal result is taken in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFFFFFF, 3'b111);
    tick();
    drive(1'b1, 32'h00500093, 3'b000);
    tick();
    chk("fl_full_valid", {63'b0, out_valid64}, 64'd1);
    chk("fl_full_err", {63'b0, err64}, 64'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00700093, 3'b000);
    #1;
    chk("fl_in_ready", {62'b0, in_ready32, in_ready64}, 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    chk("fl_valid0", {62'b0, out_valid32, out_valid64}, 64'd0);
    chk("fl_cnt64", {56'b0, cnt64}, 64'd7);
    chk("fl_cnt32", {62'b0, cnt32}, 64'd3);
    tick();
    chk("fl_valid1", {63'b0, out_valid32}, 64'd0);
    tick();
    chk("fl_valid2", {63'b0, out_valid32}, 64'd0);

    // flush on an empty pipe must still refuse the input
    flush = 1'b1;
    drive(1'b1, 32'h00900093, 3'b000);
    #1;
    chk("fl_empty_ready", {63'b0, in_ready32}, 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    chk("fl_empty_v1", {63'b0, out_valid32}, 64'd0);
    tick();
    chk("fl_empty_v2", {63'b0, out_valid32}, 64'd0);

    drive(1'b1, 32'h00B00093, 3'b000);
    tick();
    drive(1'b0, 32'h0, 3'b000);
    chk("post_fl_lat", {63'b0, out_valid32}, 64'd0);
    tick();
    chk("post_fl_valid", {63'b0, out_valid32}, 64'd1);
    chk("post_fl_imm", {32'b0, imm32}, 64'hB);
    tick();

    // asynchronous reset with a result held at the output
    out_ready = 1'b0;
    drive(1'b1, 32'h800000B7, 3'b100);
    tick();
    drive(1'b0, 32'h0, 3'b000);
    tick();
    chk("ar_pre_imm", imm64, 64'hFFFFFFFF80000000);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
    chk("ar_imm32", {32'b0, imm32}, 64'd0);
    chk("ar_imm64", imm64, 64'd0);
    chk("ar_cnt", {54'b0, cnt32, cnt64}, 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ar_ready", {63'b0, in_ready32}, 64'd1);
    drive(1'b1, 32'h0080006F, 3'b011);
    tick();
    drive(1'b0, 32'h0, 3'b000);
    tick();
    chk("ar_resume_v", {63'b0, out_valid64}, 64'd1);
    chk("ar_resume_imm", imm64, 64'h8);
    tick();
    chk("ar_resume_empty", {63'b0, out_valid64}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate generator for the multi-cycle RV32 core and its 64-bit variant. It accepts an instruction's upper 25 bits plus an immediate-format select over a valid/ready handshake and returns the sign- or zero-extended immediate two cycles later. It decodes all base formats plus the shamt and CSR-zimm formats, and flags undefined selects instead of leaving them unassigned. It sits between the instruction register and the ALU source mux, and supports stall (backpressure) and flush.

## Interface
- XLEN, 32, output width; legal values 32 or 64.
- CNT_W, 8, width of the saturating illegal-format counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous; drops every in-flight entry.
- in_valid  in  1  Instr/ImmSrc are valid.
- in_ready  out  1  combinational; block can accept this cycle.
- Instr  in  25  instruction bits [31:7]; bit n of the port is instruction bit n.
- ImmSrc  in  3  format select.
- out_valid  out  1  ImmExt/ImmErr are valid.
- out_ready  in  1  consumer takes the result this cycle.
- ImmExt  out  XLEN  extended immediate.
- ImmErr  out  1  result came from an illegal ImmSrc.
- err_count  out  CNT_W  saturating count of illegal-format results delivered.

## Operation
- **Stage S1** registers Instr, ImmSrc and s1_v.
- **Stage S2** registers the computed ImmExt, ImmErr and s2_v. out_valid = s2_v.
- **Handshake signals**
  - s2_adv = !s2_v | out_ready.
  - s1_adv = s1_v & s2_adv.
  - in_ready = !flush & (!s1_v | s2_adv).
  - Accept = in_valid & in_ready.
- **Formats** (sx = sign-extend from Instr[31] to XLEN, zx = zero-extend):
  - 000 I: sx(Instr[31:20]).
  - 001 S: sx({Instr[31:25], Instr[11:7]}).
  - 010 B: sx({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}).
  - 011 J: sx({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}).
  - 100 U: sx({Instr[31:12], 12'b0}). At XLEN=32 this equals the bits unchanged.
  - 101 SHAMT: zx(Instr[24:20]) at XLEN=32; zx(Instr[25:20]) at XLEN=64.
  - 110 ZIMM: zx(Instr[19:15]).
  - 111 illegal: ImmExt = 0, ImmErr = 1. All other formats give ImmErr = 0.
- **err_count** increments by 1 when out_valid & out_ready & ImmErr. It saturates at 2^CNT_W-1 and never wraps.
- **flush**
  - Clears s1_v and s2_v on the next edge.
  - An input presented during flush is not accepted, since in_ready = 0.
  - A result handshaked in the flush cycle counts as delivered (err_count updates).
- **Stall** (out_valid & !out_ready): S2 holds ImmExt/ImmErr stable. S1 holds if full. in_ready = 0 only when both stages are full.

## Timing
- **Reset values:** s1_v = 0, s2_v = 0, out_valid = 0, ImmExt = 0, ImmErr = 0, err_count = 0, S1 registers = 0. in_ready = 1 once reset deasserts with flush low.
- **Latency:** accept at edge N produces out_valid from just after edge N+1.
- **Throughput:** one result per cycle with out_ready held high.
- **Simultaneous events:**
  - Pop and push on a full pipe: both proceed, no bubble.
  - flush with reset: reset wins.
- **Reset mid-operation:** all entries are lost immediately (asynchronous); no output glitch persists past reset assertion.
- **Ordering:** results leave in acceptance order. No entry is duplicated or dropped except by flush or reset.

## Test plan
- **Formats, XLEN=32, out_ready=1.** Stimulus → required response, 2 cycles after each accept:
  - Instr=0xFFF00093>>7, ImmSrc=000 → ImmExt=0xFFFFFFFF.
  - 0xFE000EE3 with 010 → 0xFFFFFFFC.
  - 0x0080006F with 011 → 0x00000008.
  - 0x123450B7 with 100 → 0x12345000.
- **XLEN=64.**
  - 0x800000B7 with ImmSrc=100 → 0xFFFFFFFF80000000.
  - SHAMT from 0x03F01013 (slli x0,x0,63) → 0x000000000000003F.
- **Illegal select.** ImmSrc=111 → ImmExt=0, ImmErr=1, err_count 0→1. With CNT_W=2, five illegal results leave err_count=3.
- **Backpressure.** Push 3 back-to-back with out_ready=0.
  - in_ready drops after 2 accepts.
  - ImmExt holds the first value stable.
  - Raising out_ready then drains all 3 in order, one per cycle.
- **Flush.**
  - Fill both stages, assert flush for 1 cycle with in_valid=1 → next cycle out_valid=0, nothing accepted in the flush cycle.
  - The next accept appears 2 cycles later.
- **Async reset mid-stream.** Assert reset between edges while out_valid=1 → out_valid, ImmExt and err_count read 0 immediately. Normal operation resumes after release.
